// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, FSM encodings
// and the carry-qualification helper used by the response path.
package alu_arbiter_pkg;

  typedef logic [1:0] aluOp_t;
  typedef logic [1:0] arbState_t;

  localparam aluOp_t OP_ADD = 2'b00;
  localparam aluOp_t OP_SUB = 2'b01;
  localparam aluOp_t OP_CMP = 2'b10;
  localparam aluOp_t OP_AND = 2'b11;

  localparam arbState_t ST_IDLE = 2'b00;
  localparam arbState_t ST_EXEC = 2'b01;
  localparam arbState_t ST_HOLD = 2'b10;

  // Only the arithmetic ops produce a meaningful carry-out.
  function automatic logic opKeepsCarry(input aluOp_t op);
    logic keep;
    case (op)
      OP_ADD:  keep = 1'b1;
      OP_SUB:  keep = 1'b1;
      OP_CMP:  keep = 1'b0;
      OP_AND:  keep = 1'b0;
      default: keep = 1'b0;
    endcase
    return keep;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_grant.sv
// Two-requester round-robin grant; the pointer names the requester favoured
// when both are asking and flips to the loser after every grant.
module alu_rr_grant (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic ptrR;

  // Contention resolved by the pointer; a lone requester always wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (enable) begin
      if (req0 && req1) begin
        gnt0 = ~ptrR;
        gnt1 = ptrR;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end else begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  // Pointer moves to the requester that was not granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptrR <= 1'b0;
    end else if (gnt0) begin
      ptrR <= 1'b1;
    end else if (gnt1) begin
      ptrR <= 1'b0;
    end else begin
      ptrR <= ptrR;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one 4-bit ALU between two requesters: grant in IDLE, drive the ALU for
// one EXEC cycle, then hold the captured response in HOLD until it is taken.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Req0Valid,
  output logic             Req0Ready,
  input  logic [1:0]       Req0Op,
  input  logic [WIDTH-1:0] Req0A,
  input  logic [WIDTH-1:0] Req0B,
  input  logic             Req1Valid,
  output logic             Req1Ready,
  input  logic [1:0]       Req1Op,
  input  logic [WIDTH-1:0] Req1A,
  input  logic [WIDTH-1:0] Req1B,
  output logic [WIDTH-1:0] AluA,
  output logic [WIDTH-1:0] AluB,
  output logic [1:0]       AluS,
  input  logic [WIDTH-1:0] AluOut,
  input  logic             AluCarry,
  output logic             RspValid,
  input  logic             RspReady,
  output logic             RspId,
  output logic [WIDTH-1:0] RspData,
  output logic             RspCarry,
  output logic             Busy
);

  arbState_t        stateR;
  aluOp_t           opR;
  logic [WIDTH-1:0] aR;
  logic [WIDTH-1:0] bR;
  logic             idR;
  logic             rspValidR;
  logic             rspIdR;
  logic [WIDTH-1:0] rspDataR;
  logic             rspCarryR;
  logic             gnt0;
  logic             gnt1;
  logic             isIdle;

  assign isIdle = (stateR == ST_IDLE);

  alu_rr_grant uGrant (
    .clk    (Clk),
    .rst    (Reset),
    .enable (isIdle),
    .req0   (Req0Valid),
    .req1   (Req1Valid),
    .gnt0   (gnt0),
    .gnt1   (gnt1)
  );

  // FSM sequencing: IDLE -> EXEC on a grant, EXEC -> HOLD always, HOLD -> IDLE on RspReady.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stateR <= ST_IDLE;
    end else begin
      case (stateR)
        ST_IDLE: stateR <= (gnt0 || gnt1) ? ST_EXEC : ST_IDLE;
        ST_EXEC: stateR <= ST_HOLD;
        ST_HOLD: stateR <= RspReady ? ST_IDLE : ST_HOLD;
        default: stateR <= ST_IDLE;
      endcase
    end
  end

  // Latch the winning requester's operation at the grant edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      opR <= OP_ADD;
      aR  <= {WIDTH{1'b0}};
      bR  <= {WIDTH{1'b0}};
      idR <= 1'b0;
    end else if (isIdle && gnt1) begin
      opR <= Req1Op;
      aR  <= Req1A;
      bR  <= Req1B;
      idR <= 1'b1;
    end else if (isIdle && gnt0) begin
      opR <= Req0Op;
      aR  <= Req0A;
      bR  <= Req0B;
      idR <= 1'b0;
    end else begin
      opR <= opR;
      aR  <= aR;
      bR  <= bR;
      idR <= idR;
    end
  end

  // Capture the ALU result at the end of EXEC; release it on the consumer handshake.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rspValidR <= 1'b0;
      rspIdR    <= 1'b0;
      rspDataR  <= {WIDTH{1'b0}};
      rspCarryR <= 1'b0;
    end else if (stateR == ST_EXEC) begin
      rspValidR <= 1'b1;
      rspIdR    <= idR;
      rspDataR  <= AluOut;
      rspCarryR <= opKeepsCarry(opR) ? AluCarry : 1'b0;
    end else if ((stateR == ST_HOLD) && RspReady) begin
      rspValidR <= 1'b0;
    end else begin
      rspValidR <= rspValidR;
    end
  end

  // The shared ALU only sees operands during the single EXEC cycle.
  always_comb begin
    if (stateR == ST_EXEC) begin
      AluA = aR;
      AluB = bR;
      AluS = opR;
    end else begin
      AluA = {WIDTH{1'b0}};
      AluB = {WIDTH{1'b0}};
      AluS = 2'b00;
    end
  end

  assign Req0Ready = gnt0;
  assign Req1Ready = gnt1;
  assign RspValid  = rspValidR;
  assign RspId     = rspIdR;
  assign RspData   = rspDataR;
  assign RspCarry  = rspCarryR;
  assign Busy      = ~isIdle;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: stimulus pushes expected responses, a negedge
// monitor checks grants, ALU drive and responses against a cycle-level model.
module tb_alu_arbiter;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Req0Valid, Req1Valid;
  logic       Req0Ready, Req1Ready;
  logic [1:0] Req0Op, Req1Op;
  logic [3:0] Req0A, Req0B, Req1A, Req1B;
  logic [3:0] AluA, AluB, AluOut;
  logic [1:0] AluS;
  logic       AluCarry;
  logic       RspValid, RspReady, RspId, RspCarry, Busy;
  logic [3:0] RspData;
  logic       junkCarry;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       id;
    logic [3:0] d;
    logic       c;
  } rsp_t;
  rsp_t sb[$];

  bit         idleM = 1'b1;
  bit         execM = 1'b0;
  bit         holdM = 1'b0;
  bit         ptrM  = 1'b0;
  logic [3:0] curA, curB;
  logic [1:0] curOp;

  always #5 Clk = ~Clk;

  alu_arbiter #(.WIDTH(4)) dut (
    .Clk(Clk), .Reset(Reset),
    .Req0Valid(Req0Valid), .Req0Ready(Req0Ready), .Req0Op(Req0Op), .Req0A(Req0A), .Req0B(Req0B),
    .Req1Valid(Req1Valid), .Req1Ready(Req1Ready), .Req1Op(Req1Op), .Req1A(Req1A), .Req1B(Req1B),
    .AluA(AluA), .AluB(AluB), .AluS(AluS), .AluOut(AluOut), .AluCarry(AluCarry),
    .RspValid(RspValid), .RspReady(RspReady), .RspId(RspId), .RspData(RspData),
    .RspCarry(RspCarry), .Busy(Busy)
  );

  // Behavioural ALU; junk carry on logic ops exercises the carry qualification.
  logic [4:0] addW, subW;
  always_comb begin
    addW     = {1'b0, AluA} + {1'b0, AluB};
    subW     = {1'b0, AluA} + {1'b0, ~AluB} + 5'd1;
    AluOut   = 4'h0;
    AluCarry = 1'b0;
    case (AluS)
      2'b00: begin AluOut = addW[3:0]; AluCarry = addW[4]; end
      2'b01: begin AluOut = subW[3:0]; AluCarry = subW[4]; end
      2'b10: begin
        AluOut   = (AluA == AluB) ? 4'b0001 : ((AluA < AluB) ? 4'b0010 : 4'b0100);
        AluCarry = junkCarry;
      end
      2'b11: begin AluOut = AluA & AluB; AluCarry = junkCarry; end
      default: begin AluOut = 4'h0; AluCarry = 1'b0; end
    endcase
  end

  // Expected response from the operation's arithmetic meaning.
  function automatic rsp_t refResp(input logic id, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    rsp_t r;
    int   s;
    r.id = id;
    r.c  = 1'b0;
    case (op)
      2'b00: begin s = int'(a) + int'(b); r.d = 4'(s % 16); r.c = (s > 15); end
      2'b01: begin s = int'(a) - int'(b) + 16; r.d = 4'(s % 16); r.c = (int'(a) >= int'(b)); end
      2'b10: r.d = {1'b0, (a > b), (a < b), (a == b)};
      default: r.d = a & b;
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares this cycle's outputs with the model, then advances the model.
  always @(negedge Clk) begin
    bit g0, g1;
    g0 = 1'b0;
    g1 = 1'b0;
    if (Reset) begin
      chk("rstRspValid", int'(RspValid), 0);
      chk("rstRspId",    int'(RspId), 0);
      chk("rstRspData",  int'(RspData), 0);
      chk("rstRspCarry", int'(RspCarry), 0);
      chk("rstBusy",     int'(Busy), 0);
      chk("rstAlu",      int'({AluA, AluB, AluS}), 0);
      chk("rstReady",    int'({Req1Ready, Req0Ready}), 0);
      sb.delete();
      idleM = 1'b1; execM = 1'b0; holdM = 1'b0; ptrM = 1'b0;
    end else begin
      if (idleM) begin
        if (Req0Valid && Req1Valid) begin
          g0 = !ptrM;
          g1 = ptrM;
        end else begin
          g0 = Req0Valid;
          g1 = Req1Valid;
        end
      end
      chk("req0Ready", int'(Req0Ready), int'(g0));
      chk("req1Ready", int'(Req1Ready), int'(g1));
      chk("busy", int'(Busy), int'(!idleM));
      if (execM) begin
        chk("aluA", int'(AluA), int'(curA));
        chk("aluB", int'(AluB), int'(curB));
        chk("aluS", int'(AluS), int'(curOp));
      end else begin
        chk("aluIdle", int'({AluA, AluB, AluS}), 0);
      end
      chk("rspValid", int'(RspValid), int'(holdM));
      if (RspValid && sb.size() > 0) begin
        chk("rspId",    int'(RspId), int'(sb[0].id));
        chk("rspData",  int'(RspData), int'(sb[0].d));
        chk("rspCarry", int'(RspCarry), int'(sb[0].c));
      end
      if (holdM && RspReady) begin
        if (sb.size() > 0) void'(sb.pop_front());
        holdM = 1'b0;
        idleM = 1'b1;
      end
      if (execM) begin
        execM = 1'b0;
        holdM = 1'b1;
      end
      if (g0 || g1) begin
        curOp = g1 ? Req1Op : Req0Op;
        curA  = g1 ? Req1A : Req0A;
        curB  = g1 ? Req1B : Req0B;
        sb.push_back(refResp(g1, curOp, curA, curB));
        execM = 1'b1;
        idleM = 1'b0;
        ptrM  = g0;
      end
    end
  end

  task automatic stepCycle();
    bit t0, t1;
    @(negedge Clk);
    t0 = Req0Valid && Req0Ready;
    t1 = Req1Valid && Req1Ready;
    @(posedge Clk);
    #1;
    junkCarry = 1'($urandom_range(0, 1));
    if (t0) Req0Valid = 1'b0;
    if (t1) Req1Valid = 1'b0;
  endtask

  task automatic setReq(input bit who, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    if (who) begin
      Req1Valid = 1'b1; Req1Op = op; Req1A = a; Req1B = b;
    end else begin
      Req0Valid = 1'b1; Req0Op = op; Req0A = a; Req0B = b;
    end
  endtask

  task automatic setRand(input bit who);
    setReq(who, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (!(!Req0Valid && !Req1Valid && idleM && sb.size() == 0)) begin
      if (n >= budget) begin
        total++;
        bad++;
        $display("FAIL drainTimeout: got pending after %0d cycles expected idle", n);
        return;
      end
      stepCycle();
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    Reset = 1'b1; RspReady = 1'b0; junkCarry = 1'b0;
    Req0Valid = 1'b0; Req0Op = 2'b00; Req0A = 4'h0; Req0B = 4'h0;
    Req1Valid = 1'b0; Req1Op = 2'b00; Req1A = 4'h0; Req1B = 4'h0;
    stepCycle();
    stepCycle();
    Reset = 1'b0;
    RspReady = 1'b1;

    // Directed add, subtract and compare.
    setReq(1'b0, 2'b00, 4'h7, 4'h5);
    drain(20);
    setReq(1'b1, 2'b01, 4'h3, 4'h5);
    drain(20);
    setReq(1'b0, 2'b10, 4'h2, 4'h9);
    drain(20);

    // Both requesters continuously valid: grants must alternate.
    setRand(1'b0);
    setRand(1'b1);
    for (int i = 0; i < 15; i++) begin
      stepCycle();
      if (!Req0Valid) setRand(1'b0);
      if (!Req1Valid) setRand(1'b1);
    end
    drain(30);

    // Consumer stalls in HOLD; a waiting requester is served right after release.
    RspReady = 1'b0;
    setRand(1'b1);
    for (int i = 0; i < 8; i++) begin
      stepCycle();
      if (i == 3) setRand(1'b0);
    end
    RspReady = 1'b1;
    drain(30);

    // Reset during EXEC drops the operation and restarts the pointer.
    setReq(1'b0, 2'b00, 4'h9, 4'h9);
    n = 0;
    while (Req0Valid && n < 10) begin
      stepCycle();
      n++;
    end
    Reset = 1'b1;
    stepCycle();
    Reset = 1'b0;
    setRand(1'b0);
    setRand(1'b1);
    drain(30);
    setReq(1'b1, 2'b11, 4'hA, 4'h6);
    drain(20);

    // Randomized traffic with random consumer back-pressure.
    for (int i = 0; i < 400; i++) begin
      if (!Req0Valid && $urandom_range(0, 2) == 0) setRand(1'b0);
      if (!Req1Valid && $urandom_range(0, 2) == 0) setRand(1'b1);
      RspReady = ($urandom_range(0, 3) != 0);
      stepCycle();
    end
    RspReady = 1'b1;
    drain(50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
